// File: rtl/i2s_tx.sv
// Philips I2S transmitter: 16-bit stereo, 32 bit slots per frame, bit clock
// derived from clk_sys by a BCK_DIV half-period divider.
module i2s_tx #(
    parameter int BCK_DIV     = 8,
    parameter int UNSIGNED_IN = 0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] left_chan,
    input  logic [15:0] right_chan,
    input  logic        mute,
    output logic        sample_ack,
    output logic        I2S_BCK,
    output logic        I2S_LRCK,
    output logic        I2S_DATA
);

    localparam logic [7:0]  CNT_LAST  = 8'(BCK_DIV - 1);
    localparam logic [15:0] MSB_FLIP  = (UNSIGNED_IN != 0) ? 16'h8000 : 16'h0000;
    localparam logic [4:0]  SLOT_LAST = 5'd31;

    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [4:0]  slot;
    logic [4:0]  slot_nxt;
    logic [31:0] shreg;
    logic        wrap;
    logic        fall;
    logic        bck_nxt;
    logic        load_nxt;
    logic [15:0] left_word;
    logic [15:0] right_word;

    // Next-state view of the divider so sample_ack can be registered yet
    // still be high in exactly the cycle whose closing edge captures inputs.
    always_comb begin
        wrap       = (cnt == CNT_LAST);
        fall       = wrap && I2S_BCK;
        cnt_nxt    = wrap ? 8'd0 : cnt + 8'd1;
        bck_nxt    = I2S_BCK ^ wrap;
        slot_nxt   = fall ? slot + 5'd1 : slot;
        load_nxt   = (cnt_nxt == CNT_LAST) && bck_nxt && (slot_nxt == SLOT_LAST);
        left_word  = mute ? 16'h0000 : (left_chan ^ MSB_FLIP);
        right_word = mute ? 16'h0000 : (right_chan ^ MSB_FLIP);
    end

    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other, which is what the slot pipeline relies on.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt        <= 8'd0;
            I2S_BCK    <= 1'b0;
            slot       <= SLOT_LAST;
            I2S_LRCK   <= 1'b1;
            I2S_DATA   <= 1'b0;
            shreg      <= 32'h0000_0000;
            sample_ack <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            I2S_BCK    <= bck_nxt;
            sample_ack <= load_nxt;
            if (fall) begin
                slot     <= slot_nxt;
                I2S_LRCK <= slot_nxt[4];
                // Slot 0 still emits the previous right LSB: one-bit Philips delay.
                I2S_DATA <= shreg[31];
                if (slot_nxt == 5'd0) begin
                    shreg <= {left_word, right_word};
                end else begin
                    shreg <= {shreg[30:0], 1'b0};
                end
            end
        end
    end

endmodule
